// File: rtl/rx_line_buffer_if.sv
// Handshake bundle between the UART character stage, the line buffer and the command layer.
// The slave modport is the line buffer's view of the bundle.
interface rx_line_buffer_if #(
  parameter int LEN_W = 7
);
  logic [7:0]       i_char;
  logic             i_finished;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  logic [LEN_W-1:0] o_len;
  logic             o_overflow;
  logic             o_drop;

  modport slave (
    input  i_char, i_finished, i_ready,
    output o_data, o_valid, o_last, o_len, o_overflow, o_drop
  );

  modport master (
    output i_char, i_finished, i_ready,
    input  o_data, o_valid, o_last, o_len, o_overflow, o_drop
  );
endinterface

// File: rtl/rx_line_buffer.sv
// Assembles received bytes into an editable line (BS/DEL, CR/LF terminate) and
// streams the finished line out as a valid/ready byte sequence with a last marker.
//
// state   | meaning
// COLLECT | accepting characters into the line buffer
// DRAIN   | presenting the completed line; incoming bytes are dropped
module rx_line_buffer #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input logic               i_clk,
  input logic               i_rst,
  rx_line_buffer_if.slave   bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rd_idx;
  logic             valid_q;
  logic             last_q;
  logic             overflow_q;
  logic             drop_q;
  logic [7:0]       line_mem [MAX_LEN];

  logic is_term;
  logic is_erase;
  logic room;

  always_comb begin
    is_term  = (bus.i_char == 8'h0D) || (bus.i_char == 8'h0A);
    is_erase = (bus.i_char == 8'h08) || (bus.i_char == 8'h7F);
    room     = (len < MAX_LEN_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= COLLECT;
      len        <= '0;
      rd_idx     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.i_finished) begin
            if (is_term) begin
              // An empty line (e.g. the LF of a CR LF pair) is swallowed.
              if (len != '0) begin
                state   <= DRAIN;
                rd_idx  <= '0;
                valid_q <= 1'b1;
                last_q  <= (len == LEN_W'(1));
              end
            end else if (is_erase) begin
              if (len != '0) len <= len - LEN_W'(1);
            end else if (room) begin
              len <= len + LEN_W'(1);
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          drop_q <= bus.i_finished;
          if (bus.i_ready) begin
            if (last_q) begin
              state      <= COLLECT;
              len        <= '0;
              rd_idx     <= '0;
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              overflow_q <= 1'b0;
            end else begin
              rd_idx <= rd_idx + LEN_W'(1);
              last_q <= ((rd_idx + LEN_W'(2)) == len);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Storage is deliberately not reset; only indices below len are ever read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == COLLECT && bus.i_finished && !is_term && !is_erase && room)
      line_mem[len[IDX_W-1:0]] <= bus.i_char;
  end

  assign bus.o_data     = valid_q ? line_mem[rd_idx[IDX_W-1:0]] : 8'h00;
  assign bus.o_valid    = valid_q;
  assign bus.o_last     = last_q;
  assign bus.o_len      = len;
  assign bus.o_overflow = overflow_q;
  assign bus.o_drop     = drop_q;

endmodule

// File: tb/tb_rx_line_buffer.sv
// Directed bench for rx_line_buffer: a queue-based line model is checked every cycle,
// and the received lines are pinned against hand-written literal strings.
module tb_rx_line_buffer;
  localparam int MAXL = 4;
  localparam int LW   = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_line_buffer_if #(.LEN_W(LW)) bus();

  rx_line_buffer #(.MAX_LEN(MAXL), .LEN_W(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
  endtask

  // Line-level model: the line being typed, the line being drained and its read position.
  byte unsigned cur_line[$];
  bit           cur_ovf = 0;
  byte unsigned drn_line[$];
  bit           drn_ovf = 0;
  bit           draining = 0;
  int           drn_pos = 0;
  bit           exp_drop = 0;
  bit           model_ok = 0;

  string got_line = "";
  string got_lines[$];

  always @(posedge clk) begin
    bit nd;
    nd = 0;
    if (rst) begin
      cur_line.delete(); drn_line.delete();
      cur_ovf = 0; drn_ovf = 0; draining = 0; drn_pos = 0;
      got_line = "";
      model_ok = 1;
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        got_line = {got_line, string'(bus.o_data)};
        if (bus.o_last) begin
          got_lines.push_back(got_line);
          got_line = "";
        end
      end
      if (draining) begin
        nd = bus.i_finished;
        if (bus.i_ready) begin
          drn_pos++;
          if (drn_pos == drn_line.size()) begin
            draining = 0; drn_pos = 0; drn_ovf = 0;
            drn_line.delete();
          end
        end
      end else if (bus.i_finished) begin
        if (bus.i_char == 8'h0D || bus.i_char == 8'h0A) begin
          if (cur_line.size() > 0) begin
            drn_line = cur_line; drn_ovf = cur_ovf;
            draining = 1; drn_pos = 0;
            cur_line.delete(); cur_ovf = 0;
          end
        end else if (bus.i_char == 8'h08 || bus.i_char == 8'h7F) begin
          if (cur_line.size() > 0) void'(cur_line.pop_back());
        end else if (cur_line.size() < MAXL) begin
          cur_line.push_back(bus.i_char);
        end else begin
          cur_ovf = 1;
        end
      end
    end
    exp_drop = nd;
  end

  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      check("valid",    int'(bus.o_valid),    int'(draining));
      check("data",     int'(bus.o_data),     draining ? int'(drn_line[drn_pos]) : 0);
      check("last",     int'(bus.o_last),     int'(draining && drn_pos == drn_line.size() - 1));
      check("len",      int'(bus.o_len),      draining ? drn_line.size() : cur_line.size());
      check("overflow", int'(bus.o_overflow), int'(draining ? drn_ovf : cur_ovf));
      check("drop",     int'(bus.o_drop),     int'(exp_drop));
    end
  end

  task automatic send(input byte unsigned b);
    bus.i_char = b; bus.i_finished = 1'b1;
    @(negedge clk);
    bus.i_finished = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(byte'(s[i]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bus.i_char = 8'h00; bus.i_finished = 1'b0; bus.i_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_len",   int'(bus.o_len),   0);
    check("rst_data",  int'(bus.o_data),  0);
    check("rst_ovf",   int'(bus.o_overflow), 0);

    // Basic line
    send_str("AB"); send(8'h0D);
    check("basic_valid", int'(bus.o_valid), 1);
    check("basic_d0",    int'(bus.o_data), 8'h41);
    check("basic_len",   int'(bus.o_len), 2);
    idle(1);
    check("basic_d1",    int'(bus.o_data), 8'h42);
    check("basic_last",  int'(bus.o_last), 1);
    idle(1);
    check("basic_done",  int'(bus.o_valid), 0);
    idle(2);

    // CR LF and empty lines
    send(8'h0D); send(8'h0A); send_str("X"); send(8'h0A);
    check("crlf_len", int'(bus.o_len), 1);
    idle(3);

    // Editing, then backspace on an empty line
    send_str("ABC"); send(8'h08); send(8'h7F); send_str("Z"); send(8'h0D);
    check("edit_len", int'(bus.o_len), 2);
    idle(3);
    send(8'h08);
    check("bs_empty_len", int'(bus.o_len), 0);
    idle(2);

    // Overflow
    send_str("ABCDEF"); send(8'h0D);
    check("ovf_flag", int'(bus.o_overflow), 1);
    check("ovf_len",  int'(bus.o_len), 4);
    idle(4);
    check("ovf_clear", int'(bus.o_overflow), 0);
    send_str("Q"); send(8'h0D);
    check("q_ovf", int'(bus.o_overflow), 0);
    idle(3);

    // Backpressure and drop
    bus.i_ready = 1'b0;
    send_str("HI"); send(8'h0D);
    idle(2);
    send(8'h78);
    check("bp_drop", int'(bus.o_drop), 1);
    check("bp_data", int'(bus.o_data), 8'h48);
    idle(1);
    check("bp_drop_end", int'(bus.o_drop), 0);
    check("bp_valid",    int'(bus.o_valid), 1);
    idle(1);
    bus.i_ready = 1'b1;
    idle(4);

    // Reset in the middle of a drain
    bus.i_ready = 1'b0;
    send_str("ABC"); send(8'h0D);
    bus.i_ready = 1'b1;
    idle(1);
    bus.i_ready = 1'b0; rst = 1'b1;
    idle(1);
    rst = 1'b0; bus.i_ready = 1'b1;
    check("mid_rst_valid", int'(bus.o_valid), 0);
    check("mid_rst_len",   int'(bus.o_len), 0);
    send_str("D"); send(8'h0D);
    idle(3);

    check("line_count", got_lines.size(), 7);
    if (got_lines.size() == 7) begin
      check_str("line0", got_lines[0], "AB");
      check_str("line1", got_lines[1], "X");
      check_str("line2", got_lines[2], "AZ");
      check_str("line3", got_lines[3], "ABCD");
      check_str("line4", got_lines[4], "Q");
      check_str("line5", got_lines[5], "HI");
      check_str("line6", got_lines[6], "D");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
